ccd_frame_capture: RTL and testbench
====================================

# ccd_frame_capture

Front-end capture stage between the camera sensor pins and the Bayer-to-edge processing stage. It registers the raw 12-bit sensor pixel bus and the frame/line valid strobes, gates capture to whole frames under start/stop control, and produces the qualified pixel stream with aligned column/row coordinates. Its outputs `oDATA`, `oDVAL`, `oX_Cont` and `oY_Cont` drive `iDATA`, `iDVAL`, `iX_Cont` and `iY_Cont` of the image processing stage directly. A frame counter is provided for display and debug.

## Interface
- `H_ACTIVE`, 1280, pixels per line; the column counter wraps here.
- `V_ACTIVE`, 960, lines per frame; the row counter wraps here.
- `iCLK`  in  1  pixel clock; all logic runs on its rising edge.
- `iRST`  in  1  reset, asynchronous, active-low.
- `iDATA`  in  12  raw sensor pixel.
- `iFVAL`  in  1  sensor frame valid.
- `iLVAL`  in  1  sensor line valid.
- `iSTART`  in  1  single-cycle pulse; arms capture.
- `iEND`  in  1  single-cycle pulse; stops capture at the next frame end.
- `oDATA`  out  12  captured pixel; holds its value between valid pixels.
- `oDVAL`  out  1  qualifies `oDATA`, `oX_Cont` and `oY_Cont`.
- `oX_Cont`  out  11  column of the pixel on `oDATA`.
- `oY_Cont`  out  11  row of the pixel on `oDATA`.
- `oFrame_Cont`  out  32  count of completed captured frames.
- `oCapturing`  out  1  high in the CAPTURE and STOP_PEND states.

## Operation
- **Input stage.** `iDATA`, `iFVAL` and `iLVAL` are registered once (stage 1). `fval_d` is the previous value of stage-1 FVAL.
  - Frame start: stage-1 FVAL is 1 and `fval_d` is 0.
  - Frame end: stage-1 FVAL is 0 and `fval_d` is 1.
- **State machine.** Four states: IDLE, ARMED, CAPTURE, STOP_PEND.
  - IDLE: `iSTART` moves to ARMED. If `iSTART` and `iEND` arrive in the same cycle, `iEND` wins and the block stays in IDLE.
  - ARMED: a frame start moves to CAPTURE. `iEND` moves back to IDLE. A frame already in progress is never captured partially.
  - CAPTURE: `iEND` moves to STOP_PEND. `iSTART` is ignored. At each frame end, `oFrame_Cont` increments by 1.
  - STOP_PEND: capture continues. At the frame end, `oFrame_Cont` increments and the state moves to IDLE. `iSTART` is ignored.
- **Valid pixel.** A pixel is valid when stage-1 FVAL and stage-1 LVAL are both high and the state is CAPTURE or STOP_PEND. The frame-start cycle qualifies when the state is ARMED, so the first pixel of the frame is kept.
- **Coordinates.** Internal next-coordinate counters `nx`/`ny` track the position of the next pixel.
  - A frame start clears `nx` and `ny` to 0.
  - On each valid pixel: `oDATA` loads stage-1 data, `oX_Cont` loads `nx`, `oY_Cont` loads `ny`, and `oDVAL` is 1.
  - Normal advance: `nx` increments.
  - End of line: when `nx` is H_ACTIVE-1, `nx` goes to 0 and `ny` increments. When `ny` is also V_ACTIVE-1, `ny` wraps to 0.
- **Short line.** When stage-1 LVAL falls (1 to 0) and `nx` is not 0, `nx` clears and `ny` increments using the same wrap rule. A line of exactly H_ACTIVE pixels causes no extra row increment.
- **Idle outputs.** On cycles with no valid pixel, `oDVAL` is 0 and `oDATA`, `oX_Cont` and `oY_Cont` hold their values.
- **`oFrame_Cont`** wraps modulo 2^32.
- **Reset.** Assertion of `iRST` at any time, including mid-frame, forces:
  - state to IDLE;
  - all stage registers, `nx` and `ny` to 0;
  - `oDATA`=0, `oDVAL`=0, `oX_Cont`=0, `oY_Cont`=0, `oFrame_Cont`=0, `oCapturing`=0.
  
  After release, capture needs `iSTART` followed by a new frame start. If FVAL is already high at release, that frame is skipped.

## Timing
- Pixel latency is 2 cycles: `iDATA` sampled at edge N appears on `oDATA` with `oDVAL`=1 after edge N+1.
- `oX_Cont` and `oY_Cont` change in the same cycle as `oDATA`. They are valid combinationally alongside `oDVAL`.
- State transitions take effect at the edge after the qualifying event.
- `oCapturing` rises one cycle after the frame start is detected.
- `oCapturing` falls, and `oFrame_Cont` updates, on the edge following the frame end seen in stage 1.
- Throughput is one pixel per clock. There is no back-pressure.

## Test plan
- **Reset defaults:** hold `iRST`=0 with arbitrary inputs, then release → every output is 0, state is IDLE, and no `oDVAL` pulses appear while FVAL/LVAL toggle without `iSTART`.
- **Arm mid-frame:** pulse `iSTART` while FVAL is high → no pixels from the current frame. The next frame's first pixel appears with `oX_Cont`=0, `oY_Cont`=0, 2 cycles after its input.
- **Full frame:** send 1280×960 pixels with `iDATA` = column count → `oX_Cont` runs 0..1279 per line, `oY_Cont` runs 0..959, and `oDATA`=`oX_Cont`. Exactly 1,228,800 `oDVAL` cycles. `oFrame_Cont` becomes 1 after FVAL falls.
- **Short lines:** send 3 lines of 100 pixels each → rows 0, 1, 2 each start at X=0. `oX_Cont` peaks at 99.
- **Stop:** pulse `iEND` mid-frame 2 → frame 2 completes, `oFrame_Cont`=2, `oCapturing`=0, and frame 3 produces no `oDVAL`. Also pulse `iSTART` and `iEND` together in IDLE → the block stays IDLE.
- **Reset mid-frame:** assert `iRST` at row 500 → all outputs are 0 immediately. After release, `iSTART` plus the next frame start restarts at X=0, Y=0 with `oFrame_Cont`=0.

Source files
------------

// File: rtl/ccd_frame_capture.sv
// Sensor front end: registers the raw pixel bus and FVAL/LVAL, gates capture to whole
// frames under start/stop control, and emits qualified pixels with column/row coordinates.
module ccd_frame_capture #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oCapturing
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, STOP_PEND} state_t;

  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

  state_t      state;
  logic [11:0] data_s1;
  logic        fval_s1, lval_s1, fval_d, lval_d;
  logic [10:0] nx, ny, cur_nx, cur_ny, ny_inc;
  logic        frame_start, frame_end, lval_fall, active, pix_vld;

  always_comb begin
    frame_start = fval_s1 & ~fval_d;
    frame_end   = ~fval_s1 & fval_d;
    lval_fall   = ~lval_s1 & lval_d;
    // The frame-start cycle counts as active while armed so the first pixel is kept.
    active      = (state == CAPTURE) || (state == STOP_PEND) ||
                  ((state == ARMED) && frame_start);
    pix_vld     = fval_s1 & lval_s1 & active;
    cur_nx      = frame_start ? 11'd0 : nx;
    cur_ny      = frame_start ? 11'd0 : ny;
    ny_inc      = (cur_ny == Y_LAST) ? 11'd0 : cur_ny + 11'd1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_s1 <= '0;
      fval_s1 <= 1'b0;
      lval_s1 <= 1'b0;
      fval_d  <= 1'b0;
      lval_d  <= 1'b0;
    end else begin
      data_s1 <= iDATA;
      fval_s1 <= iFVAL;
      lval_s1 <= iLVAL;
      fval_d  <= fval_s1;
      lval_d  <= lval_s1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      nx      <= '0;
      ny      <= '0;
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL <= pix_vld;
      if (pix_vld) begin
        oDATA   <= data_s1;
        oX_Cont <= cur_nx;
        oY_Cont <= cur_ny;
        if (cur_nx == X_LAST) begin
          nx <= '0;
          ny <= ny_inc;
        end else begin
          nx <= cur_nx + 11'd1;
          ny <= cur_ny;
        end
      end else if (lval_fall && cur_nx != 11'd0) begin
        // Line ended short of H_ACTIVE: move to the next row anyway.
        nx <= '0;
        ny <= ny_inc;
      end else begin
        nx <= cur_nx;
        ny <= cur_ny;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      oFrame_Cont <= '0;
      oCapturing  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (iSTART && !iEND) state <= ARMED;
        ARMED: begin
          if (frame_start) begin
            state      <= iEND ? STOP_PEND : CAPTURE;
            oCapturing <= 1'b1;
          end else if (iEND) begin
            state <= IDLE;
          end
        end
        CAPTURE: begin
          if (frame_end) oFrame_Cont <= oFrame_Cont + 32'd1;
          if (iEND) state <= STOP_PEND;
        end
        STOP_PEND: begin
          if (frame_end) begin
            oFrame_Cont <= oFrame_Cont + 32'd1;
            state       <= IDLE;
            oCapturing  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          oCapturing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed bench for ccd_frame_capture on a reduced 8x4 geometry.
module tb_ccd_frame_capture;
  localparam int H = 8;
  localparam int V = 4;

  logic        iCLK = 0, iRST = 0;
  logic [11:0] iDATA = '0;
  logic        iFVAL = 0, iLVAL = 0, iSTART = 0, iEND = 0;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont, oY_Cont;
  logic [31:0] oFrame_Cont;
  logic        oCapturing;

  ccd_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oCapturing(oCapturing)
  );

  always #5 iCLK = ~iCLK;

  typedef struct { int x; int y; int d; int c; } px_t;
  px_t q[$];
  int  cyc = 0;
  int  first_drv = 0;
  int  checks = 0, errors = 0;

  always @(posedge iCLK) begin
    #1;
    cyc++;
    if (oDVAL === 1'b1) q.push_back('{int'(oX_Cont), int'(oY_Cont), int'(oDATA), cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge iCLK);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(oDATA), 0);
    chk({tag, "_dval"}, 32'(oDVAL), 0);
    chk({tag, "_x"}, 32'(oX_Cont), 0);
    chk({tag, "_y"}, 32'(oY_Cont), 0);
    chk({tag, "_fcnt"}, oFrame_Cont, 0);
    chk({tag, "_capt"}, 32'(oCapturing), 0);
  endtask

  // One frame: FVAL and LVAL rise together, lines of len pixels with a 2-cycle blank.
  task automatic send_frame(input int lines, input int len, input int start_line,
                            input int end_line, input int rst_line);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < len; p++) begin
        tick;
        iFVAL  = 1; iLVAL = 1;
        iDATA  = 12'(l * 16 + p);
        iSTART = (p == 0 && l == start_line);
        iEND   = (p == 0 && l == end_line);
        if (l == 0 && p == 0) first_drv = cyc;
        if (l == rst_line && p == 3) begin
          iRST = 0; #1;
          chk_zero("rst_mid");
          tick;
          iRST = 1; iLVAL = 0; iSTART = 0; iEND = 0;
          return;
        end
      end
      repeat (2) begin
        tick;
        iLVAL = 0; iSTART = 0; iEND = 0;
      end
    end
    tick; iFVAL = 0;
    repeat (4) tick;
  endtask

  // Compare captured stream against raster order for a frame of line length h.
  task automatic chk_seq(input string tag, input int n, input int h);
    int bad = 0;
    chk({tag, "_count"}, 32'(q.size()), 32'(n));
    foreach (q[i]) begin
      if (q[i].x != i % h || q[i].y != (i / h) % V || q[i].d != (i / h) * 16 + i % h) bad++;
    end
    chk({tag, "_seq_bad"}, 32'(bad), 0);
  endtask

  initial begin
    int mx;
    // Reset with toggling inputs
    for (int i = 0; i < 6; i++) begin
      tick;
      iDATA = 12'($urandom); iFVAL = i[0]; iLVAL = i[1]; iSTART = 1;
    end
    #1 chk_zero("rst_hold");
    tick; iRST = 1; iDATA = 0; iFVAL = 0; iLVAL = 0; iSTART = 0;
    repeat (2) tick;
    chk_zero("rst_rel");
    q.delete();
    send_frame(V, H, -1, -1, -1);
    chk("no_start_count", 32'(q.size()), 0);
    chk("no_start_capt", 32'(oCapturing), 0);

    // Arm mid-frame: current frame skipped, next one captured whole
    q.delete();
    send_frame(V, H, 1, -1, -1);
    chk("arm_mid_count", 32'(q.size()), 0);
    chk("arm_mid_capt", 32'(oCapturing), 0);
    q.delete();
    send_frame(V, H, -1, -1, -1);
    chk_seq("full", H * V, H);
    if (q.size() > 0) begin
      chk("full_lat", 32'(q[0].c - first_drv), 2);
      chk("full_last_x", 32'(q[q.size()-1].x), H - 1);
      chk("full_last_y", 32'(q[q.size()-1].y), V - 1);
    end
    chk("full_fcnt", oFrame_Cont, 1);
    chk("full_capt", 32'(oCapturing), 1);

    // Extra line wraps the row counter
    q.delete();
    send_frame(V + 1, H, -1, -1, -1);
    chk_seq("wrap", H * (V + 1), H);
    if (q.size() > H * V) chk("wrap_y", 32'(q[H*V].y), 0);
    chk("wrap_fcnt", oFrame_Cont, 2);

    // Short lines
    q.delete();
    send_frame(3, 5, -1, -1, -1);
    chk_seq("short", 15, 5);
    mx = 0;
    foreach (q[i]) if (q[i].x > mx) mx = q[i].x;
    chk("short_max_x", 32'(mx), 4);
    if (q.size() == 15) begin
      chk("short_row1", 32'(q[5].y * 100 + q[5].x), 100);
      chk("short_row2", 32'(q[10].y * 100 + q[10].x), 200);
    end
    chk("short_fcnt", oFrame_Cont, 3);

    // Stop mid-frame
    q.delete();
    send_frame(V, H, -1, 1, -1);
    chk_seq("stop", H * V, H);
    chk("stop_fcnt", oFrame_Cont, 4);
    chk("stop_capt", 32'(oCapturing), 0);
    q.delete();
    send_frame(V, H, -1, -1, -1);
    chk("after_stop_count", 32'(q.size()), 0);
    chk("after_stop_fcnt", oFrame_Cont, 4);

    // Start and end together in IDLE
    tick; iSTART = 1; iEND = 1;
    tick; iSTART = 0; iEND = 0;
    q.delete();
    send_frame(V, H, -1, -1, -1);
    chk("startend_count", 32'(q.size()), 0);
    chk("startend_capt", 32'(oCapturing), 0);

    // Reset mid-frame, release with FVAL high
    tick; iSTART = 1;
    tick; iSTART = 0;
    send_frame(V, H, -1, -1, 2);
    repeat (3) tick;
    iSTART = 1;
    tick; iSTART = 0;
    repeat (2) tick;
    chk("post_rst_capt", 32'(oCapturing), 0);
    iFVAL = 0;
    repeat (3) tick;
    chk("post_rst_fcnt0", oFrame_Cont, 0);
    q.delete();
    send_frame(V, H, -1, -1, -1);
    chk_seq("restart", H * V, H);
    if (q.size() > 0) chk("restart_lat", 32'(q[0].c - first_drv), 2);
    chk("restart_fcnt", oFrame_Cont, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
